// File: rtl/button_cmd_conditioner.sv
// Two-button front end: synchronise, debounce and edge-detect each push button,
// then queue press events into a single-slot valid/ready command output.
// Optional auto-repeat while a button is held: define BUTTON_AUTO_REPEAT_EN.
module button_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] push_buttons,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  input  logic       cmd_ready,
  output logic       cmd_dropped
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      stable_q;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press_evt;
  logic [1:0]      evt;
  logic [1:0]      pending;
  logic [1:0]      load_sel;
  logic [1:0]      pending_nxt;
  logic [1:0]      drop_vec;
  logic            slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= push_buttons;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples
  // that differ from the current stable level; any return clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable    <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_q <= 2'b00;
    else       stable_q <= stable;
  end

  assign press_evt = stable & ~stable_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_cnt [2];
  logic [1:0]        repeating;
  logic [1:0]        rep_evt;

  // hold_cnt is 0 on the press-event cycle, so a match at the limit lands
  // exactly REPEAT_DELAY (then REPEAT_PERIOD) cycles after the previous event.
  always_comb begin
    rep_evt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rep_evt[i] = stable[i] & (hold_cnt[i] == (repeating[i] ? HOLD_PERIOD : HOLD_DELAY));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt[0] <= '0;
      hold_cnt[1] <= '0;
      repeating   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!stable[i]) begin
          hold_cnt[i]  <= '0;
          repeating[i] <= 1'b0;
        end else if (rep_evt[i]) begin
          hold_cnt[i]  <= HOLD_W'(1);
          repeating[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign evt = press_evt | rep_evt;
`else
  assign evt = press_evt;
`endif

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both 1; cmd_valid/cmd_code hold steady until that edge and
  // the slot may be refilled from pending on the same edge.
  assign slot_free = ~cmd_valid | cmd_ready;

  always_comb begin
    load_sel = 2'b00;
    if (slot_free) begin
      if (pending[0])      load_sel = 2'b01;
      else if (pending[1]) load_sel = 2'b10;
    end
  end

  // An event on a bit that is loaded this cycle re-arms it rather than dropping.
  assign pending_nxt = (pending & ~load_sel) | evt;
  assign drop_vec    = evt & pending & ~load_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 2'b00;
      cmd_dropped <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 2'b00;
    end else begin
      pending     <= pending_nxt;
      cmd_dropped <= |drop_vec;
      if (slot_free) begin
        cmd_valid <= |load_sel;
        cmd_code  <= load_sel;
      end
    end
  end

endmodule
